// File: rtl/led_fade_pwm_pkg.sv
// Shared constants for the LED fade/PWM stage.
// Default clock and width give roughly a 1 s full-scale fade.
package led_pkg;

  localparam int LED_COUNT        = 4;
  localparam int CLK_FREQ_HZ      = 50_000_000;
  localparam int PWM_BITS         = 8;
  localparam int FADE_STEP_CYCLES = CLK_FREQ_HZ / ((1 << PWM_BITS) - 1);

  // A one-cycle step period still needs a 1-bit counter.
  function automatic int step_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: saturating brightness level plus registered PWM compare.
// Define LED_FADE_GAMMA_EN for a square-law (perceptual) duty curve.
module led_fade_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                target,
  output logic                led_out,
  output logic                at_target
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] duty;

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] square;
  assign square = level * level;
  assign duty   = square[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty = level;
`endif

  assign at_target = target ? (level == MAX) : (level == '0);

  // Level only moves toward the target on a tick, so it saturates at the endpoints.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level   <= '0;
      led_out <= 1'b0;
    end else begin
      if (tick && !at_target) begin
        level <= target ? level + 1'b1 : level - 1'b1;
      end
      led_out <= (level == MAX) || (duty > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// LED crossfade stage: registers the sequencer pattern and PWM-fades each channel.
// Optional square-law duty curve via LED_FADE_GAMMA_EN (see led_fade_channel).
module led_fade_pwm #(
  parameter int LED_COUNT   = led_pkg::LED_COUNT,
  parameter int PWM_BITS    = led_pkg::PWM_BITS,
  parameter int STEP_CYCLES = led_pkg::FADE_STEP_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LED_COUNT-1:0] led_in,
  output logic [LED_COUNT-1:0] led_out,
  output logic                 busy
);

  import led_pkg::*;

  localparam int SW = step_width(STEP_CYCLES);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  logic [LED_COUNT-1:0] target;
  logic [LED_COUNT-1:0] at_target;
  logic [SW-1:0]        step_cnt;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic                 tick;

  assign tick = (step_cnt == STEP_LAST);

  // Step and PWM counters free-run; pattern changes never restart them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target   <= '0;
      step_cnt <= '0;
      pwm_cnt  <= '0;
      busy     <= 1'b0;
    end else begin
      target   <= led_in;
      step_cnt <= tick ? '0 : step_cnt + 1'b1;
      pwm_cnt  <= pwm_cnt + 1'b1;
      busy     <= ~&at_target;
    end
  end

  for (genvar i = 0; i < LED_COUNT; i++) begin : g_chan
    led_fade_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .pwm_cnt   (pwm_cnt),
      .target    (target[i]),
      .led_out   (led_out[i]),
      .at_target (at_target[i])
    );
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Randomized bench for led_fade_pwm (PWM_BITS=4, STEP_CYCLES=4) against a
// behavioural brightness model.
module tb_led_fade_pwm;

  localparam int N      = 4;
  localparam int PB     = 4;
  localparam int STEP   = 4;
  localparam int LVLMAX = (1 << PB) - 1;
  localparam int PERIOD = 1 << PB;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] led_in;
  logic [N-1:0] led_out;
  logic         busy;

  int vectors;
  int miscompares;

  int           m_level [N];
  logic [N-1:0] m_target;
  logic [N-1:0] m_led;
  logic         m_busy;
  int           m_cyc;

  led_fade_pwm #(
    .LED_COUNT   (N),
    .PWM_BITS    (PB),
    .STEP_CYCLES (STEP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .led_in  (led_in),
    .led_out (led_out),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dutyOf(input int lvl);
`ifdef LED_FADE_GAMMA_EN
    return (lvl * lvl) / PERIOD;
`else
    return lvl;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) m_level[i] = 0;
    m_target = '0;
    m_led    = '0;
    m_busy   = 1'b0;
    m_cyc    = 0;
  endtask

  // One clock of the model: m_cyc counts edges since reset, so the fade
  // step happens every STEP-th edge and the PWM phase is m_cyc mod PERIOD.
  task automatic modelStep();
    bit tick;
    int phase;
    tick   = (m_cyc % STEP) == STEP - 1;
    phase  = m_cyc % PERIOD;
    m_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_led[i] = (m_level[i] == LVLMAX) || (dutyOf(m_level[i]) > phase);
      if (m_target[i] ? (m_level[i] != LVLMAX) : (m_level[i] != 0)) m_busy = 1'b1;
      if (tick) begin
        if (m_target[i] && m_level[i] < LVLMAX) m_level[i]++;
        else if (!m_target[i] && m_level[i] > 0) m_level[i]--;
      end
    end
    m_target = led_in;
    m_cyc++;
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic applyStimulus(input logic [N-1:0] pattern, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      led_in = pattern;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("led_out", 32'(led_out), 32'(m_led));
      checkOutput("busy", 32'(busy), 32'(m_busy));
      @(negedge clk);
    end
  endtask

  task automatic pulseReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_led", 32'(led_out), 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    modelReset();
    rst_n  = 1'b0;
    led_in = 4'b1111;
    repeat (3) @(negedge clk);
    checkOutput("reset_led", 32'(led_out), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    rst_n  = 1'b1;
    led_in = '0;

    applyStimulus(4'b0000, 500);

    // Fade up: busy rises two edges after the pattern change.
    applyStimulus(4'b0001, 1);
    checkOutput("busy_lat1", 32'(busy), 32'd0);
    applyStimulus(4'b0001, 1);
    checkOutput("busy_lat2", 32'(busy), 32'd1);
    applyStimulus(4'b0001, 80);
    checkOutput("full_on", 32'(led_out), 32'b0001);
    checkOutput("full_idle", 32'(busy), 32'd0);

    // Reversal mid-fade, then crossfade from a steady channel.
    applyStimulus(4'b0000, 30);
    applyStimulus(4'b0001, 30);
    applyStimulus(4'b0000, 60);
    applyStimulus(4'b0001, 80);
    applyStimulus(4'b0010, 80);

    // Reset in the middle of a fade.
    applyStimulus(4'b0100, 38);
    pulseReset();
    applyStimulus(4'b0100, 80);

    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 7) == 0) pulseReset();
      applyStimulus(4'($urandom_range(0, 15)), $urandom_range(1, 70));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
